neurram_spi_responder: RTL



---
 rtl/neurram_pkg.sv | 12 +
 rtl/neurram_scan_lane.sv | 25 ++
 rtl/neurram_spi_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/neurram_pkg.sv
// Shared definitions for the NeuRRAM scan-chain responder.
// State encoding and lane count.
package neurram_pkg;

  typedef enum logic {
    RSP_IDLE   = 1'b0,
    RSP_ACTIVE = 1'b1
  } rsp_state_t;

  localparam int SPI_LANES = 2;

endpackage

// File: rtl/neurram_scan_lane.sv
// One lane of the on-chip scan chain.
// Shifts right (MSB in) on shift_en; a shift beats a parallel load.
module neurram_scan_lane #(
  parameter int LEN = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift_en,
  input  logic           serial_in,
  input  logic           load_en,
  input  logic [LEN-1:0] load_data,
  output logic [LEN-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {serial_in, data[LEN-1:1]};
    end else if (load_en) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/neurram_spi_responder.sv
// Chip-side responder for the two-lane NeuRRAM scan interface.
// Edge detect, frame FSM and counters; lanes are sub-modules.
module neurram_spi_responder
  import neurram_pkg::*;
#(
  parameter int CHAIN_LENGTH   = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                spi_clk,
  input  logic [1:0]                          shift_in,
  output logic [1:0]                          shift_out,
  input  logic                                load_en,
  input  logic [2*CHAIN_LENGTH-1:0]           load_data,
  output logic [2*CHAIN_LENGTH-1:0]           frame_data,
  output logic                                frame_valid,
  output logic                                frame_abort,
  output logic                                load_collision,
  output logic                                busy,
  output logic [$clog2(CHAIN_LENGTH):0]       bit_count,
  output logic [15:0]                         frame_count
);

  localparam int BW = $clog2(CHAIN_LENGTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  rsp_state_t state, state_n;
  logic spi_clk_d;
  logic rise;
  logic load_go;
  logic coll_n;
  logic done;
  logic abort_n;
  logic [BW-1:0] bit_n;
  logic [BW-1:0] bit_inc;
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_n;
  logic [SPI_LANES-1:0][CHAIN_LENGTH-1:0] chain;
  logic [2*CHAIN_LENGTH-1:0] shifted;

  assign rise    = spi_clk & ~spi_clk_d;
  assign busy    = (state == RSP_ACTIVE);
  assign load_go = load_en & ~rise & (state == RSP_IDLE);
  assign coll_n  = load_en & ~load_go;
  assign bit_inc = bit_count + 1'b1;

  for (genvar i = 0; i < SPI_LANES; i++) begin : g_lane
    neurram_scan_lane #(
      .LEN(CHAIN_LENGTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .shift_en (rise),
      .serial_in(shift_in[i]),
      .load_en  (load_go),
      .load_data(load_data[i*CHAIN_LENGTH +: CHAIN_LENGTH]),
      .data     (chain[i])
    );
    // Post-shift view so a completing frame captures the final bit.
    assign shifted[i*CHAIN_LENGTH +: CHAIN_LENGTH] =
      {shift_in[i], chain[i][CHAIN_LENGTH-1:1]};
    assign shift_out[i] = chain[i][0];
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_count;
    idle_n  = idle_cnt;
    done    = 1'b0;
    abort_n = 1'b0;
    unique case (state)
      RSP_IDLE: begin
        idle_n = '0;
        if (rise) begin
          state_n = RSP_ACTIVE;
          bit_n   = BW'(1);
        end
      end
      RSP_ACTIVE: begin
        if (rise) begin
          idle_n = '0;
          bit_n  = bit_inc;
          if (bit_inc == BW'(CHAIN_LENGTH)) begin
            done    = 1'b1;
            bit_n   = '0;
            state_n = RSP_IDLE;
          end
        end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          abort_n = 1'b1;
          bit_n   = '0;
          idle_n  = '0;
          state_n = RSP_IDLE;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RSP_IDLE;
      spi_clk_d      <= 1'b0;
      bit_count      <= '0;
      idle_cnt       <= '0;
      frame_valid    <= 1'b0;
      frame_abort    <= 1'b0;
      load_collision <= 1'b0;
      frame_count    <= '0;
      frame_data     <= '0;
    end else begin
      state          <= state_n;
      spi_clk_d      <= spi_clk;
      bit_count      <= bit_n;
      idle_cnt       <= idle_n;
      frame_valid    <= done;
      frame_abort    <= abort_n;
      load_collision <= coll_n;
      if (done) begin
        frame_data  <= shifted;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
